// File: rtl/rr_pkg.sv
// Shared definitions for the round-robin arbiter and its grant/transfer consumer:
// FSM state encoding plus one-hot helpers usable on any vector up to MAX_W bits.
package rr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam int MAX_W = 32;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [MAX_W-1:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

  // Index of the set bit of a one-hot vector (highest set bit if not one-hot).
  function automatic int onehot_idx(input logic [MAX_W-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_W; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_grant_xfer_if.sv
// Signal bundle between the arbiter/requesters/downstream side (master) and the
// grant/transfer block (slave).
//
// Handshakes: a requester beat is consumed on a rising edge where req_pop[i]=1;
// req_pop only asserts while req_valid[i]=1. An output beat transfers on a rising
// edge where out_valid && out_ready; while out_valid && !out_ready the beat
// (out_data/out_src/out_last) is held unchanged, and out_valid never drops
// without a transfer except through reset.
interface rr_grant_xfer_if #(
  parameter int WIDTH  = 4,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
);
  logic [WIDTH-1:0]        grant;
  logic [WIDTH-1:0]        req_valid;
  logic [WIDTH*DATA_W-1:0] req_data;
  logic [WIDTH*LEN_W-1:0]  req_len;
  logic [WIDTH-1:0]        req_pop;
  logic                    ack;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic [WIDTH-1:0]        out_src;
  logic                    out_last;
  logic                    err_grant;

  modport master (
    output grant, req_valid, req_data, req_len, out_ready,
    input  req_pop, ack, out_valid, out_data, out_src, out_last, err_grant
  );

  modport slave (
    input  grant, req_valid, req_data, req_len, out_ready,
    output req_pop, ack, out_valid, out_data, out_src, out_last, err_grant
  );
endinterface

// File: rtl/rr_skid_fifo2.sv
// Two-entry FIFO with registered storage. A push is accepted when full if a pop
// happens the same cycle, so a single stream sustains one beat per cycle.
module rr_skid_fifo2 #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] mem0;
  logic [W-1:0] mem1;
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  // Flow control: full only blocks a push when the head is not leaving.
  always_comb begin
    out_valid = (count != 2'd0);
    in_ready  = (count != 2'd2) || out_ready;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    out_data  = rd_ptr ? mem1 : mem0;
  end

  // Storage and pointers; on a full push+pop the write lands in the slot being freed.
  always_ff @(posedge clk) begin
    if (resetb) begin
      mem0   <= '0;
      mem1   <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) mem1 <= in_data;
        else        mem0 <= in_data;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rr_grant_xfer.sv
// Consumer of the round-robin arbiter: latches a one-hot grant, moves req_len+1
// beats from the granted requester into the output FIFO, then pulses ack once.
import rr_pkg::*;

module rr_grant_xfer #(
  parameter int WIDTH  = 4,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic           clk,
  input  logic           resetb,
  rr_grant_xfer_if.slave bus,
  output state_t         state
);

  localparam int PW = DATA_W + WIDTH + 1;

  state_t            state_q;
  state_t            state_d;
  logic [WIDTH-1:0]  sel;
  logic [LEN_W-1:0]  cnt;
  logic              err_q;
  logic              grant_onehot;
  logic              grant_multi;
  logic [LEN_W-1:0]  len_sel;
  logic [DATA_W-1:0] data_sel;
  logic              fifo_in_ready;
  logic              beat;
  logic [PW-1:0]     push_word;
  logic [PW-1:0]     pop_word;

  assign state = state_q;

  // Grant classification and one-hot muxing of the requester fields.
  always_comb begin
    grant_onehot = is_onehot(MAX_W'(bus.grant));
    grant_multi  = (bus.grant != '0) && !grant_onehot;
    len_sel      = '0;
    data_sel     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.grant[i]) len_sel  = bus.req_len[i*LEN_W +: LEN_W];
      if (sel[i])       data_sel = bus.req_data[i*DATA_W +: DATA_W];
    end
    // A beat is never consumed on a reset edge, so an aborted burst loses nothing
    // beyond what was already popped.
    beat      = (state_q == XFER) && !resetb && ((bus.req_valid & sel) != '0)
                && fifo_in_ready;
    push_word = {data_sel, sel, (cnt == '0)};
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (resetb) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: a burst ends on the beat pushed with cnt==0.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_onehot) state_d = XFER;
      XFER:    if (beat && (cnt == '0)) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Burst context: latched grant, remaining-beat counter and sticky grant error.
  always_ff @(posedge clk) begin
    if (resetb) begin
      sel   <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if ((state_q == IDLE) && grant_onehot) begin
        sel <= bus.grant;
        cnt <= len_sel;
      end
      if ((state_q == IDLE) && grant_multi) err_q <= 1'b1;
      if (beat && (cnt != '0)) cnt <= cnt - 1'b1;
    end
  end

  // FSM outputs towards requesters and arbiter.
  always_comb begin
    bus.req_pop   = beat ? sel : '0;
    bus.ack       = (state_q == ACK);
    bus.err_grant = err_q;
  end

  rr_skid_fifo2 #(.W(PW)) u_fifo (
    .clk       (clk),
    .resetb    (resetb),
    .in_valid  (beat),
    .in_ready  (fifo_in_ready),
    .in_data   (push_word),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (pop_word)
  );

  assign {bus.out_data, bus.out_src, bus.out_last} = pop_word;

endmodule

// File: tb/tb_rr_grant_xfer.sv
// Bench for rr_grant_xfer: requesters serve beats from per-requester data streams,
// expected output beats are queued per granted burst, and a monitor compares every
// output transfer, pop legality and output hold behaviour.
module tb_rr_grant_xfer;
  import rr_pkg::*;

  localparam int WIDTH  = 4;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;
  localparam int PW     = DATA_W + WIDTH + 1;
  localparam int DEPTH  = 1024;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   resetb;
  state_t state;

  always #5 clk = ~clk;

  rr_grant_xfer_if #(.WIDTH(WIDTH), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  rr_grant_xfer #(.WIDTH(WIDTH), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus),
    .state  (state)
  );

  // ---------------- reference model state ----------------
  int                vectors     = 0;
  int                miscompares = 0;
  logic [DATA_W-1:0] beats [WIDTH][DEPTH];
  int                pop_seen [WIDTH];
  logic [PW-1:0]     exp_q[$];
  int                burst_pops;
  logic [WIDTH-1:0]  cur_src;
  bit                rand_mode;
  logic              prev_stall;
  logic [PW-1:0]     prev_word;
  logic [PW-1:0]     mon_word;
  logic [PW-1:0]     exp_word;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) begin
      bus.req_valid = WIDTH'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < WIDTH; i++)
      bus.req_data[i*DATA_W +: DATA_W] = beats[i][pop_seen[i] % DEPTH];
  endtask

  // One burst: grant requester idx for len+1 beats.
  // mode 0: all valid, out_ready high; mode 1: out_ready low for 6 cycles; mode 2: random.
  task automatic run_burst(input int idx, input int len, input int mode);
    int               k;
    int               pre;
    bit               got;
    logic [WIDTH-1:0] g;
    g = WIDTH'(1) << idx;
    tick();
    pre = exp_q.size();
    bus.req_len[idx*LEN_W +: LEN_W] = LEN_W'(len);
    bus.grant  = g;
    cur_src    = g;
    burst_pops = 0;
    for (int b = 0; b <= len; b++)
      exp_q.push_back({beats[idx][(pop_seen[idx] + b) % DEPTH], g, 1'(b == len)});
    if (mode == 0) begin bus.req_valid = '1; bus.out_ready = 1'b1; end
    if (mode == 1) begin bus.req_valid = '1; bus.out_ready = 1'b0; end
    rand_mode = (mode == 2);
    @(negedge clk);
    chk("idle_at_grant", state, IDLE);
    chk("no_ack_at_grant", bus.ack, 0);
    k   = 0;
    got = 0;
    while (!got && k < 300) begin
      tick();
      k++;
      if (k == 1) bus.grant = '0;
      if (mode == 1 && k == 6) begin
        chk("stall_pops", burst_pops, 2);
        bus.out_ready = 1'b1;
      end
      @(negedge clk);
      if (mode == 0 && pre == 0 && k == 1) chk("first_out_n1", bus.out_valid, 0);
      if (mode == 0 && pre == 0 && k == 2) chk("first_out_n2", bus.out_valid, 1);
      if (bus.ack === 1'b1) got = 1;
    end
    rand_mode = 0;
    chk("ack_seen", got, 1);
    if (mode == 0) chk("ack_latency", k, len + 2);
    chk("burst_pops", burst_pops, len + 1);
  endtask

  task automatic drain();
    rand_mode     = 0;
    bus.out_ready = 1'b1;
    repeat (8) tick();
    chk("drained", exp_q.size(), 0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  // Sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (resetb === 1'b0) begin
      mon_word = {bus.out_data, bus.out_src, bus.out_last};
      chk("pop_needs_valid", bus.req_pop & ~bus.req_valid, 0);
      if (bus.req_pop != '0) chk("pop_src", bus.req_pop, cur_src);
      for (int i = 0; i < WIDTH; i++) begin
        if (bus.req_pop[i]) begin
          pop_seen[i]++;
          burst_pops++;
        end
      end
      if (prev_stall) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_word", mon_word, prev_word);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("spurious_beat", exp_q.size(), 1);
        else begin
          exp_word = exp_q.pop_front();
          chk("out_beat", mon_word, exp_word);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_word  = mon_word;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int rr_ptr;
    int nxt;
    for (int i = 0; i < WIDTH; i++) begin
      pop_seen[i] = 0;
      for (int j = 0; j < DEPTH; j++) beats[i][j] = DATA_W'($urandom);
    end
    rand_mode     = 0;
    cur_src       = '0;
    burst_pops    = 0;
    prev_stall    = 1'b0;
    resetb        = 1'b1;
    bus.grant     = '0;
    bus.req_valid = '0;
    bus.req_len   = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    resetb = 1'b0;
    @(negedge clk);
    chk("rst_state", state, IDLE);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_req_pop", bus.req_pop, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_src", bus.out_src, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_err_grant", bus.err_grant, 0);

    // Basic 3-beat burst, then the same under backpressure.
    run_burst(1, 2, 0);
    run_burst(1, 2, 1);
    drain();

    // Multi-hot grant in IDLE.
    tick();
    bus.grant = 4'b0110;
    cur_src   = '0;
    @(negedge clk);
    chk("multi_idle", state, IDLE);
    tick();
    bus.grant = '0;
    @(negedge clk);
    chk("multi_err", bus.err_grant, 1);
    chk("multi_no_pop", bus.req_pop, 0);
    chk("multi_state", state, IDLE);
    tick();
    @(negedge clk);
    chk("multi_no_ack", bus.ack, 0);
    run_burst(0, 1, 0);
    chk("err_sticky", bus.err_grant, 1);

    // Single-beat burst, next grant arriving right after ACK.
    run_burst(3, 0, 0);
    run_burst(0, 2, 0);
    drain();

    // Reset mid-burst with one beat buffered.
    tick();
    bus.req_len[2*LEN_W +: LEN_W] = LEN_W'(5);
    bus.grant     = 4'b0100;
    cur_src       = 4'b0100;
    bus.req_valid = '1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    tick();
    bus.grant = '0;
    @(negedge clk);
    chk("abort_one_pop", bus.req_pop, 4'b0100);
    tick();
    resetb = 1'b1;
    @(negedge clk);
    tick();
    resetb = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_ack", bus.ack, 0);
    chk("abort_state", state, IDLE);
    tick();
    @(negedge clk);
    chk("abort_no_late_ack", bus.ack, 0);
    bus.out_ready = 1'b1;
    run_burst(2, 3, 0);
    chk("err_after_reset", bus.err_grant, 0);

    // Round-robin arbiter model with requests 1010, back to back.
    rr_ptr = 0;
    repeat (4) begin
      nxt = -1;
      for (int o = 1; o <= WIDTH; o++) begin
        int c;
        c = (rr_ptr + o) % WIDTH;
        if ((4'b1010 >> c) & 1 && nxt < 0) nxt = c;
      end
      run_burst(nxt, int'($urandom_range(0, 3)), 0);
      rr_ptr = nxt;
    end
    drain();

    // Random bursts with random valid/backpressure.
    repeat (20) run_burst(int'($urandom_range(0, WIDTH - 1)), int'($urandom_range(0, 15)), 2);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
